alu2_sequencer: RTL

ALU2_SEQUENCER -- requirements
Module: alu2_sequencer

---
 rtl/alu2_pkg.sv | 19 +
 rtl/alu2_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu2_pkg.sv
// rtl/alu2_pkg.sv - op encodings shared with the child ALU and sequencer state enum
package alu2_pkg;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] MUL  = 3'b001;
    localparam logic [2:0] SGE  = 3'b010;
    localparam logic [2:0] PASS = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_MUL,
        S_ACC,
        S_BIAS,
        S_CMP,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu2_sequencer.sv
// rtl/alu2_sequencer.sv - neuron sequencer driving an external child ALU (sum of x*w + bias, threshold)
// Optional macro ALU2_SEQ_RELU_EN: DONE presents out_sum=0 when the threshold flag is clear.
module alu2_sequencer
    import alu2_pkg::*;
#(
    parameter int nBits = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [nBits-1:0] bias,
    input  logic [nBits-1:0] thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nBits-1:0] in_x,
    input  logic [nBits-1:0] in_w,
    output logic [2:0]       ALU2Control,
    output logic [nBits-1:0] ALUResult1,
    output logic [nBits-1:0] SrcC,
    input  logic [nBits-1:0] ALUResult,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nBits-1:0] out_sum,
    output logic             out_fire
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_cnt;
    logic [nBits-1:0]   r_bias;
    logic [nBits-1:0]   r_thresh;
    logic [nBits-1:0]   r_x;
    logic [nBits-1:0]   r_w;
    logic [nBits-1:0]   r_prod;
    logic [nBits-1:0]   r_acc;
    logic               r_fire;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last_pair;

    assign w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_last_pair = (w_cnt_inc == r_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = (count != '0) ? S_WAIT_IN : S_BIAS;
            S_WAIT_IN: if (in_valid) w_next_state = S_MUL;
            S_MUL:     w_next_state = S_ACC;
            S_ACC:     w_next_state = w_last_pair ? S_BIAS : S_WAIT_IN;
            S_BIAS:    w_next_state = S_CMP;
            S_CMP:     w_next_state = S_DONE;
            S_DONE:    if (out_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Every ALU result is consumed in the same cycle it is requested.
    always_comb begin
        ALU2Control = PASS;
        ALUResult1  = '0;
        SrcC        = '0;
        in_ready    = 1'b0;
        busy        = (r_state != S_IDLE);
        out_valid   = 1'b0;
        out_sum     = '0;
        out_fire    = 1'b0;
        case (r_state)
            S_WAIT_IN: in_ready = 1'b1;
            S_MUL: begin
                ALU2Control = MUL;
                ALUResult1  = r_x;
                SrcC        = r_w;
            end
            S_ACC: begin
                ALU2Control = ADD;
                ALUResult1  = r_acc;
                SrcC        = r_prod;
            end
            S_BIAS: begin
                ALU2Control = ADD;
                ALUResult1  = r_acc;
                SrcC        = r_bias;
            end
            S_CMP: begin
                ALU2Control = SGE;
                ALUResult1  = r_acc;
                SrcC        = r_thresh;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_fire  = r_fire;
`ifdef ALU2_SEQ_RELU_EN
                out_sum   = r_fire ? r_acc : '0;
`else
                out_sum   = r_acc;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_cnt    <= '0;
            r_bias   <= '0;
            r_thresh <= '0;
            r_x      <= '0;
            r_w      <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_fire   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count  <= count;
                        r_bias   <= bias;
                        r_thresh <= thresh;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_fire   <= 1'b0;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        r_x <= in_x;
                        r_w <= in_w;
                    end
                end
                S_MUL:  r_prod <= ALUResult;
                S_ACC: begin
                    r_acc <= ALUResult;
                    r_cnt <= w_cnt_inc;
                end
                S_BIAS: r_acc  <= ALUResult;
                S_CMP:  r_fire <= ALUResult[0];
                default: ;
            endcase
        end
    end

endmodule
